// File: rtl/irq_priority_dispatcher.sv
// Priority arbiter and APB claim/complete sequencer feeding the core's external interrupt.
// Optional claim-to-complete watchdog is built when IRQ_DISPATCH_TIMEOUT_EN is defined.
module irq_priority_dispatcher #(
  parameter int NSRC    = 32,
  parameter int PRIO_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [31:0]       paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic              pwrite_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic [NSRC-1:0]   pending_i,
  output logic              irq_o,
  output logic [NSRC-1:0]   clr_o,
  output logic [4:0]        claim_id_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] thresh_q;
  logic              to_sticky_q;
  logic              bad_sticky_q;

  logic [5:0]        addr;
  logic              wr_en, rd_setup;
  logic              claim_rd, cpl_wr, cpl_match, cpl_bad, sts_wr;
  logic [4:0]        best_id;
  logic [PRIO_W-1:0] best_prio;
  logic              any_elig;
  logic              to_hit;
  logic [31:0]       rd_word;
  logic              unused_ok;

  assign pready_o  = 1'b1;
  assign pslverr_o = 1'b0;
  assign irq_o     = (state_q == PEND);
  assign unused_ok = ^{paddr_i[31:8], paddr_i[1:0]};

  assign addr      = paddr_i[7:2];
  assign wr_en     = psel_i & penable_i & pwrite_i;
  assign rd_setup  = psel_i & ~penable_i & ~pwrite_i;
  assign claim_rd  = rd_setup && (addr == 6'd5) && (state_q == PEND);
  assign cpl_wr    = wr_en && (addr == 6'd6);
  assign cpl_match = cpl_wr && (state_q == ACTIVE) && (pwdata_i[4:0] == claim_id_o);
  assign cpl_bad   = cpl_wr && !cpl_match;
  assign sts_wr    = wr_en && (addr == 6'd7);

  // Strict '>' while scanning upward keeps the lowest index on equal priority.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (pending_i[k] && (prio_q[k] > thresh_q) && (prio_q[k] > best_prio)) begin
        best_prio = prio_q[k];
        best_id   = 5'(k);
      end
    end
  end

  // Eligible sources always have prio > THRESH >= 0, so a non-zero best means something won.
  assign any_elig = (best_prio != '0);

`ifdef IRQ_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] to_cnt_q;

  assign to_hit = (state_q == ACTIVE) && (to_cnt_q == CNT_W'(TIMEOUT - 1)) && !cpl_match;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ACTIVE) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig) state_d = PEND;
      PEND:    if (claim_rd) state_d = ACTIVE;
               else if (!any_elig) state_d = IDLE;
      ACTIVE:  if (cpl_match || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      6'd0, 6'd1, 6'd2, 6'd3: begin
        for (int k = 0; k < NSRC; k++) begin
          if (addr == 6'(k / 8)) rd_word[4*(k%8) +: 4] = 4'(prio_q[k]);
        end
      end
      6'd4: rd_word[PRIO_W-1:0] = thresh_q;
      6'd5: if (claim_rd) rd_word = {1'b1, 26'd0, claim_id_o};
      6'd7: begin
        rd_word[1:0]   = state_q;
        rd_word[8]     = to_sticky_q;
        rd_word[9]     = bad_sticky_q;
        rd_word[20:16] = claim_id_o;
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      claim_id_o   <= '0;
      clr_o        <= '0;
      prdata_o     <= '0;
      thresh_q     <= '0;
      to_sticky_q  <= 1'b0;
      bad_sticky_q <= 1'b0;
      for (int k = 0; k < NSRC; k++) prio_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      prdata_o <= rd_setup ? rd_word : 32'd0;
      // The id returned by a claim is frozen; re-arbitration only runs in IDLE/PEND.
      if (((state_q == IDLE) || (state_q == PEND && !claim_rd)) && any_elig)
        claim_id_o <= best_id;
      clr_o <= claim_rd ? (NSRC'(1) << claim_id_o) : '0;
      for (int k = 0; k < NSRC; k++) begin
        if (wr_en && addr == 6'(k / 8)) prio_q[k] <= pwdata_i[4*(k%8) +: PRIO_W];
      end
      if (wr_en && addr == 6'd4) thresh_q <= pwdata_i[PRIO_W-1:0];
      if (to_hit) to_sticky_q <= 1'b1;
      else if (sts_wr && pwdata_i[8]) to_sticky_q <= 1'b0;
      if (cpl_bad) bad_sticky_q <= 1'b1;
      else if (sts_wr && pwdata_i[9]) bad_sticky_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_priority_dispatcher.sv
// Bench for irq_priority_dispatcher: register table, arbitration, claim/complete and reset corners.
module tb_irq_priority_dispatcher;
  localparam int NSRC = 32;
  localparam int PRIO_W = 4;
  localparam int TB_TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr, irq;
  logic [NSRC-1:0] pending, clr;
  logic [4:0] claim_id;

  irq_priority_dispatcher #(.NSRC(NSRC), .PRIO_W(PRIO_W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
    .pwdata_i(pwdata), .pwrite_i(pwrite), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .pending_i(pending), .irq_o(irq), .clr_o(clr), .claim_id_o(claim_id));

  typedef struct {
    bit          wr;
    logic [5:0]  widx;
    logic [31:0] data;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t vt[20];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] sts_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [5:0] w, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {24'd0, w, 2'b00}; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Expected read data is queued at setup and retired when the access phase presents prdata.
  task automatic apb_read(input logic [5:0] w, input logic [31:0] e, input string name);
    sb_t s;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'd0, w, 2'b00};
    s.exp = e; s.name = name;
    sbq.push_back(s);
    @(negedge clk);
    penable = 1'b1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got=0 entries expected=1");
    end else begin
      s = sbq.pop_front();
      check(s.name, prdata, s.exp);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vt[0]  = '{0, 6'd0,  32'h0,        "rst_prio0"};
    vt[1]  = '{0, 6'd1,  32'h0,        "rst_prio1"};
    vt[2]  = '{0, 6'd2,  32'h0,        "rst_prio2"};
    vt[3]  = '{0, 6'd3,  32'h0,        "rst_prio3"};
    vt[4]  = '{0, 6'd4,  32'h0,        "rst_thresh"};
    vt[5]  = '{0, 6'd5,  32'h0,        "rst_claim"};
    vt[6]  = '{0, 6'd6,  32'h0,        "rst_complete"};
    vt[7]  = '{0, 6'd7,  32'h0,        "rst_status"};
    vt[8]  = '{1, 6'd0,  32'h12345678, "wr_prio0"};
    vt[9]  = '{0, 6'd0,  32'h12345678, "rd_prio0"};
    vt[10] = '{1, 6'd3,  32'hFEDCBA98, "wr_prio3"};
    vt[11] = '{0, 6'd3,  32'hFEDCBA98, "rd_prio3"};
    vt[12] = '{1, 6'd4,  32'hFFFFFFFF, "wr_thresh"};
    vt[13] = '{0, 6'd4,  32'h0000000F, "rd_thresh_masked"};
    vt[14] = '{1, 6'd12, 32'hFFFFFFFF, "wr_unmapped"};
    vt[15] = '{0, 6'd12, 32'h0,        "rd_unmapped"};
    vt[16] = '{1, 6'd0,  32'h0,        "clr_prio0"};
    vt[17] = '{1, 6'd3,  32'h0,        "clr_prio3"};
    vt[18] = '{1, 6'd4,  32'h0,        "clr_thresh"};
    vt[19] = '{0, 6'd0,  32'h0,        "rd_prio0_cleared"};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pending = '0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_clr", clr, 32'd0);
    check("rst_claim_id", {27'd0, claim_id}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("pready", {31'd0, pready}, 32'd1);
    check("pslverr", {31'd0, pslverr}, 32'd0);

    foreach (vt[i]) begin
      if (vt[i].wr) apb_write(vt[i].widx, vt[i].data);
      else          apb_read(vt[i].widx, vt[i].data, vt[i].name);
    end

    // Source 3 at prio 5 is not above THRESH 5; lowering THRESH to 2 makes it eligible.
    apb_write(6'd0, 32'h0000_5000);
    apb_write(6'd4, 32'd5);
    pending = 32'h8;
    cycles(2);
    check("thresh_blocks_irq", {31'd0, irq}, 32'd0);
    apb_write(6'd4, 32'd2);
    @(negedge clk);
    check("basic_irq_up", {31'd0, irq}, 32'd1);
    check("basic_claim_id", {27'd0, claim_id}, 32'd3);
    apb_read(6'd5, 32'h8000_0003, "basic_claim_rd");
    check("basic_clr_pulse", clr, 32'h8);
    check("basic_irq_drop", {31'd0, irq}, 32'd0);
    pending = '0;
    @(negedge clk);
    check("basic_clr_one_cycle", clr, 32'h0);
    apb_read(6'd7, 32'h0003_0002, "basic_status_active");
    apb_write(6'd6, 32'd3);
    apb_read(6'd7, 32'h0003_0000, "basic_status_idle");

    // Priority beats index; equal priority falls back to lowest index.
    apb_write(6'd0, 32'h0400_0040);
    apb_write(6'd1, 32'h0000_0070);
    pending = 32'h242;
    cycles(2);
    check("prio_best9", {27'd0, claim_id}, 32'd9);
    apb_write(6'd1, 32'h0000_0040);
    @(negedge clk);
    check("tie_lowest1", {27'd0, claim_id}, 32'd1);
    check("tie_irq", {31'd0, irq}, 32'd1);
    pending = '0;
    cycles(2);
    check("tie_drop_irq", {31'd0, irq}, 32'd0);
    apb_write(6'd1, 32'h0);

    // Re-arbitration inside PEND, then everything withdraws.
    apb_write(6'd0, 32'h0060_0300);
    pending = 32'h4;
    cycles(2);
    check("pend_src2", {27'd0, claim_id}, 32'd2);
    pending = 32'h24;
    @(negedge clk);
    check("pend_src5", {27'd0, claim_id}, 32'd5);
    check("pend_irq_held", {31'd0, irq}, 32'd1);
    pending = '0;
    @(negedge clk);
    check("pend_idle_irq", {31'd0, irq}, 32'd0);
    apb_read(6'd7, 32'h0005_0000, "pend_status_idle");

    // ACTIVE on id 4: wrong complete, sticky clear, claim outside PEND.
    apb_write(6'd0, 32'h0005_0000);
    pending = 32'h10;
    cycles(2);
    apb_read(6'd5, 32'h8000_0004, "act_claim_rd");
    check("act_clr_pulse", clr, 32'h10);
    pending = '0;
    apb_write(6'd6, 32'd7);
    apb_read(6'd7, 32'h0004_0202, "act_bad_cpl_status");
    apb_write(6'd7, 32'h200);
    apb_read(6'd7, 32'h0004_0002, "act_bad_cleared");
    apb_read(6'd5, 32'h0, "act_claim_in_active");
    check("act_claim_no_clr", clr, 32'h0);
    apb_write(6'd6, 32'd4);
    apb_read(6'd7, 32'h0004_0000, "act_complete_idle");

    // Missing complete: watchdog (if built) or indefinite ACTIVE.
    pending = 32'h10;
    cycles(2);
    apb_read(6'd5, 32'h8000_0004, "wd_claim_rd");
    pending = '0;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    cycles(20);
    apb_read(6'd7, 32'h0004_0100, "wd_timeout_status");
    sts_base = 32'h0004_0100;
`else
    cycles(1000);
    apb_read(6'd7, 32'h0004_0002, "wd_still_active");
    apb_write(6'd6, 32'd4);
    sts_base = 32'h0004_0000;
`endif
    apb_write(6'd6, 32'd4);
    apb_read(6'd7, sts_base | 32'h200, "cpl_outside_active");
    apb_write(6'd7, 32'h300);
    apb_read(6'd7, 32'h0004_0000, "sticky_both_cleared");

    // Reset from PEND with a read in its setup phase.
    pending = 32'h10;
    cycles(2);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; penable = 1'b1;
    check("rst_inflight_rd", prdata, 32'h0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    check("rst_mid_claim_id", {27'd0, claim_id}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rst_stays_idle", {31'd0, irq}, 32'd0);
    apb_read(6'd0, 32'h0, "rst_prio0_zero");
    apb_read(6'd4, 32'h0, "rst_thresh_zero");
    pending = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_priority_dispatcher.md
Name: irq_priority_dispatcher

Overview:
- Priority arbiter and claim/complete sequencer between the subsystem interrupt controller and the CPU external-interrupt input.
- Takes the enabled pending vector from the interrupt controller, picks the highest-priority eligible source, and raises one interrupt request to the core.
- Gives the core an APB claim/complete register pair and pulses a one-hot clear back to the controller when a source is claimed.

Parameters:
- NSRC, 32, number of interrupt sources (1..32).
- PRIO_W, 4, priority field width; priority 0 means never eligible.
- TIMEOUT, 1024, cycles allowed between claim and complete (used only with the optional feature).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- psel_i  input  1  APB select
- penable_i  input  1  APB enable
- paddr_i  input  32  APB address; bits [7:2] decoded
- pwdata_i  input  32  APB write data
- pwrite_i  input  1  APB write
- prdata_o  output  32  APB read data, registered
- pready_o  output  1  tied 1
- pslverr_o  output  1  tied 0
- pending_i  input  NSRC  level pending vector (status & enable) from the interrupt controller
- irq_o  output  1  interrupt request to the core
- clr_o  output  NSRC  one-cycle one-hot clear pulse to the interrupt controller
- claim_id_o  output  5  ID currently held in the PEND or ACTIVE state

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high. All state updates on posedge clk_i only.
- Reset values:
  - prdata_o=0, irq_o=0, clr_o=0, claim_id_o=0
  - all PRIO fields=0, THRESH=0, state=IDLE, sticky bits=0, timeout counter=0
- APB access rules:
  - Write on psel&penable&pwrite.
  - Read data is registered in the setup phase (psel&~penable&~pwrite) and valid during the access phase.
  - prdata_o=0 in every other cycle.
- Register map (paddr_i[7:2]):
  - 0..3 PRIO0..PRIO3, R/W: 8 sources per word, source k at word k/8, bits [4*(k%8)+3 : 4*(k%8)]. Fields for k>=NSRC read 0 and ignore writes.
  - 4 THRESH, R/W: [PRIO_W-1:0].
  - 5 CLAIM, RO with side effect: read returns {bit31=claimed, bits[4:0]=id}.
  - 6 COMPLETE, WO: write data [4:0] is the id being completed.
  - 7 STATUS: [1:0]=state, [8]=timeout sticky, [9]=bad-complete sticky, [20:16]=claim_id_o. A write of 1 to bit 8 or bit 9 clears that bit.
  - Other addresses read 0; writes to them are ignored.
- Eligibility and selection:
  - Source k is eligible when pending_i[k] and prio[k] > THRESH, unsigned compare.
  - Best = highest prio; on a tie, the lowest index wins.
- State machine IDLE / PEND / ACTIVE:
  - IDLE: if any source is eligible in cycle t, register best id/prio and enter PEND at t+1. irq_o=1 from t+1.
  - PEND: best is re-evaluated every cycle.
    - A new best (higher prio or lower tied index) replaces claim_id_o; state stays PEND and irq_o stays 1.
    - If nothing is eligible, go to IDLE and drop irq_o next cycle.
  - PEND, CLAIM read (setup phase):
    - prdata_o = {1, id}.
    - Next cycle: state=ACTIVE, irq_o=0, clr_o[id]=1 for exactly one cycle.
  - ACTIVE: irq_o=0 and no re-arbitration.
    - COMPLETE write with id == claim_id_o: go to IDLE next cycle.
    - COMPLETE write with a mismatched id: ignored and sets bad-complete sticky.
- Boundary cases:
  - CLAIM read outside PEND: returns 0, no state change, no clr_o.
  - COMPLETE write outside ACTIVE: ignored and sets bad-complete sticky.
  - PEND source changes in the same cycle as the CLAIM setup: the value returned is the id registered that cycle, and the same id is cleared and held ACTIVE.
  - A PRIO or THRESH write takes effect for eligibility on the next cycle. It never affects ACTIVE.
  - rst_i asserted in any state forces the full reset values on the next edge. An in-flight APB read returns 0.

Optional Feature:
- Macro: IRQ_DISPATCH_TIMEOUT_EN.
- With the macro defined:
  - A counter starts at 0 on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches TIMEOUT-1 without a matching complete: force IDLE next cycle and set timeout sticky (STATUS[8]).
  - The counter is $clog2(TIMEOUT)+1 bits wide and saturates; it never wraps.
- Without the macro: no counter is present, ACTIVE is held until a matching complete, and STATUS[8] reads 0.

Test Plan:
- Reset, then read all registers -> all read 0; irq_o=0, clr_o=0.
- PRIO0 source 3=5, THRESH=2, pending_i=0x8 at cycle t -> irq_o=1 at t+1; CLAIM read returns 0x80000003; clr_o=0x8 for one cycle; irq_o=0; COMPLETE write 3 -> STATUS[1:0]=IDLE.
- Sources 1 and 6 at prio 4, source 9 at prio 7, pending_i=0x242 -> claim_id_o=9; with source 9 at prio 4 instead -> claim_id_o=1.
- PEND on source 2 prio 3; then source 5 prio 6 asserts -> claim_id_o changes to 5 while irq_o stays 1; both drop -> IDLE, irq_o=0 next cycle.
- ACTIVE on id 4, COMPLETE write 7 -> stays ACTIVE, STATUS[9]=1; write STATUS 0x200 -> bit 9 clears; CLAIM read in ACTIVE -> 0.
- With IRQ_DISPATCH_TIMEOUT_EN and TIMEOUT=16: claim, then no complete -> IDLE after 16 ACTIVE cycles, STATUS[8]=1. Without the macro -> still ACTIVE after 1000 cycles.
